nonce_sequencer: RTL and testbench
==================================

# nonce_sequencer

Downstream stage of the block storage unit in the miner top level. It captures the 352-bit initial hash state when a new block is announced and issues (state, nonce) work items to the hashing core through a valid/ready handshake, stepping through the 32-bit nonce space. It also collects winning nonces reported back by the core into a small FIFO, drops hits that belong to a superseded block, and drives the nonce buffer writer, including a sticky overflow flag.

## Interface
- NONCE_START, 0, first nonce issued for each block.
- NONCE_STEP, 1, nonce increment per issued item (interleaving across multiple miners); must be ≥1.
- HIT_DEPTH, 4, hit FIFO depth; power of two, ≥2.

- clk  input  1  system clock.
- rst  input  1  reset. Asynchronous, active-low.
- stateValid  input  1  initialState/newBlock are valid this cycle.
- newBlock  input  1  qualifies stateValid: a new block starts now.
- initialState  input  352  midstate[351:96] plus header tail[95:0].
- coreValid  output  1  work item offered to the core.
- coreReady  input  1  core accepts the item.
- coreState  output  352  latched initialState.
- coreNonce  output  32  nonce of the offered item.
- coreEpoch  output  1  block epoch tag carried with the item.
- hitValid  input  1  core reports a winning nonce.
- hitNonce  input  32  winning nonce.
- hitEpoch  input  1  epoch tag returned with the hit.
- nonceValid  output  1  FIFO head is valid.
- nonceReady  input  1  nonce buffer consumes the head.
- nonce  output  32  FIFO head nonce.
- overflow  output  1  sticky: a hit was dropped because the FIFO was full.
- searchDone  output  1  nonce space exhausted and FIFO empty.

## Operation
- FSM states: IDLE, RUN, EXHAUSTED. Reset value IDLE.
- Start event is stateValid && newBlock. In any state it latches initialState, loads nonce = NONCE_START, toggles epoch, flushes the FIFO, clears overflow, and enters RUN. stateValid without newBlock is ignored.
- RUN: coreValid = 1. On coreValid && coreReady:
  - Compute the next nonce as a 33-bit sum nonce + NONCE_STEP.
  - If bit 32 is set, the accepted item was the last one: enter EXHAUSTED.
  - Otherwise nonce takes the low 32 bits.
- EXHAUSTED: coreValid = 0. The block leaves this state only on a start event.
- Outputs coreState, coreNonce and coreEpoch stay stable while coreValid && !coreReady.
- Hit push condition: hitValid && hitEpoch == epoch && no start event this cycle. Stale-epoch hits are discarded silently and do not set overflow.
- Push when the FIFO is full and there is no pop: the hit is dropped and overflow is set.
- Push and pop in the same cycle on a full FIFO: both succeed, count is unchanged, overflow is not set.
- Pop condition: nonceValid && nonceReady.
- searchDone = (state == EXHAUSTED) && FIFO empty.
- A start event during RUN aborts the current block. Work already accepted by the core returns with the old epoch and is dropped.

## Timing
- Reset values: coreValid 0, coreNonce 0, coreState 0, coreEpoch 0, nonceValid 0, nonce 0, overflow 0, searchDone 0.
- Start event in cycle N: coreValid = 1 with coreNonce = NONCE_START in cycle N+1.
- Back-to-back acceptance yields one item per cycle. The nonce advances in the cycle after each handshake.
- Hit latency: a hit accepted in cycle N gives nonceValid = 1 in N+1 (FIFO empty, show-ahead).
- A start event coinciding with hitValid: the hit is discarded, and the FIFO is empty in N+1.
- Reset mid-operation: all state returns to reset values immediately and asynchronously.

## Structure
- Shared package bcminer_pkg holds:
  - STATE_W = 352 and NONCE_W = 32;
  - the typedef enum seq_state_t {IDLE, RUN, EXHAUSTED}.
- Sub-module hit_fifo is parameterized by width and depth. It provides show-ahead output, synchronous flush, and full/empty/count outputs. The sequencer instantiates it for 32-bit nonces.

## Test plan
- Reset, then start with a known state and coreReady = 1 for 5 cycles: coreNonce goes 0,1,2,3,4; coreState equals the input; coreEpoch = 1.
- NONCE_START = 0xFFFFFFFE, NONCE_STEP = 1, coreReady held high: items 0xFFFFFFFE and 0xFFFFFFFF are issued, then coreValid = 0 and searchDone = 1.
- coreReady low for 3 cycles mid-run: coreNonce is held at 7 and coreState is stable; once ready, the next value is 8.
- HIT_DEPTH = 4 with nonceReady low and 5 matching hits (0x10..0x14): overflow = 1 and the FIFO holds 0x10..0x13. Raising nonceReady drains them in order.
- Start a second block, then send a hit tagged with the old epoch: the hit is not queued, nonceValid stays 0, and overflow has been cleared.
- FIFO full, then push 0x20 and pop in the same cycle: overflow stays 0 and 0x20 is the last entry.

Source files
------------

// File: rtl/bcminer_pkg.sv
// Shared types and widths for the miner datapath.
package bcminer_pkg;

    localparam int STATE_W = 352;
    localparam int NONCE_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXHAUSTED
    } seq_state_t;

endpackage

// File: rtl/hit_fifo.sv
// Small show-ahead FIFO with synchronous flush. The head entry is visible on
// dout whenever the FIFO is not empty. A push into a full FIFO only succeeds
// when a pop happens in the same cycle.
module hit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    // Storage array: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is 2^AW.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/nonce_sequencer.sv
// Issues (state, nonce) work items to the hashing core for the current block,
// walks the nonce space until the 32-bit range is exhausted, and queues the
// winning nonces reported back for the nonce buffer writer. An epoch bit tags
// every item so that hits from an aborted block can be recognised and dropped.
module nonce_sequencer
    import bcminer_pkg::*;
#(
    parameter logic [NONCE_W-1:0] NONCE_START = '0,
    parameter logic [NONCE_W-1:0] NONCE_STEP  = 1,
    parameter int                 HIT_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stateValid,
    input  logic               newBlock,
    input  logic [STATE_W-1:0] initialState,
    output logic               coreValid,
    input  logic               coreReady,
    output logic [STATE_W-1:0] coreState,
    output logic [NONCE_W-1:0] coreNonce,
    output logic               coreEpoch,
    input  logic               hitValid,
    input  logic [NONCE_W-1:0] hitNonce,
    input  logic               hitEpoch,
    output logic               nonceValid,
    input  logic               nonceReady,
    output logic [NONCE_W-1:0] nonce,
    output logic               overflow,
    output logic               searchDone
);

    seq_state_t                state_reg;
    seq_state_t                state_next;
    logic [NONCE_W-1:0]        nonce_reg;
    logic [NONCE_W-1:0]        nonce_next;
    logic [NONCE_W:0]          nonce_sum;
    logic [STATE_W-1:0]        block_reg;
    logic                      epoch_reg;
    logic                      overflow_reg;

    logic                      start_evt;
    logic                      handshake;
    logic                      hit_push;
    logic                      hit_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(HIT_DEPTH):0] fifo_count;
    logic [NONCE_W-1:0]        fifo_head;

    assign start_evt  = stateValid && newBlock;
    assign coreValid  = (state_reg == RUN);
    assign handshake  = coreValid && coreReady;
    assign coreState  = block_reg;
    assign coreNonce  = nonce_reg;
    assign coreEpoch  = epoch_reg;

    // Hits from an older block or coinciding with a restart never reach the FIFO.
    assign hit_push   = hitValid && (hitEpoch == epoch_reg) && !start_evt;
    assign nonceValid = !fifo_empty;
    assign hit_pop    = nonceValid && nonceReady;
    assign nonce      = fifo_empty ? '0 : fifo_head;
    assign overflow   = overflow_reg;
    assign searchDone = (state_reg == EXHAUSTED) && (fifo_count == '0);

    // Next-state and nonce stepping; the carry out of the 33-bit sum marks the last item.
    always_comb begin
        state_next = state_reg;
        nonce_next = nonce_reg;
        nonce_sum  = {1'b0, nonce_reg} + {1'b0, NONCE_STEP};
        if (start_evt) begin
            state_next = RUN;
            nonce_next = NONCE_START;
        end else begin
            case (state_reg)
                RUN: begin
                    if (handshake) begin
                        if (nonce_sum[NONCE_W]) begin
                            state_next = EXHAUSTED;
                        end else begin
                            nonce_next = nonce_sum[NONCE_W-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and current nonce registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            nonce_reg <= '0;
        end else begin
            state_reg <= state_next;
            nonce_reg <= nonce_next;
        end
    end

    // Block state capture and epoch toggle on every new block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            block_reg <= '0;
            epoch_reg <= 1'b0;
        end else if (start_evt) begin
            block_reg <= initialState;
            epoch_reg <= ~epoch_reg;
        end
    end

    // Sticky overflow: set when a valid hit finds the FIFO full with no pop, cleared by a new block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_reg <= 1'b0;
        end else if (start_evt) begin
            overflow_reg <= 1'b0;
        end else if (hit_push && fifo_full && !hit_pop) begin
            overflow_reg <= 1'b1;
        end
    end

    hit_fifo #(
        .WIDTH (NONCE_W),
        .DEPTH (HIT_DEPTH)
    ) u_hit_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start_evt),
        .push  (hit_push),
        .din   (hitNonce),
        .pop   (hit_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_nonce_sequencer.sv
// Bench for nonce_sequencer: two instances (default start, and a start just
// below the top of the nonce space) share one stimulus stream and are checked
// every cycle against a behavioural model built from counters and a queue.
module tb_nonce_sequencer;

    localparam int DEPTH = 4;
    localparam longint unsigned TOP = 64'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         stateValid, newBlock, coreReady, hitValid, hitEpoch, nonceReady;
    logic [351:0] initialState;
    logic [31:0]  hitNonce;

    logic         cv0, ce0, nv0, ov0, sd0, cv1, ce1, nv1, ov1, sd1;
    logic [351:0] cs0, cs1;
    logic [31:0]  cn0, nn0, cn1, nn1;

    int tests = 0;
    int fails = 0;

    // behavioural model
    longint unsigned m_start [2] = '{64'h0, 64'hFFFF_FFFE};
    longint unsigned m_nonce [2];
    bit              m_run   [2];
    bit              m_exh   [2];
    logic [351:0]    m_state;
    bit              m_epoch;
    bit              m_ovf;
    logic [31:0]     hq [$];

    always #5 clk = ~clk;

    nonce_sequencer #(.NONCE_START(32'h0), .NONCE_STEP(32'd1), .HIT_DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst(rst), .stateValid(stateValid), .newBlock(newBlock),
        .initialState(initialState), .coreValid(cv0), .coreReady(coreReady),
        .coreState(cs0), .coreNonce(cn0), .coreEpoch(ce0), .hitValid(hitValid),
        .hitNonce(hitNonce), .hitEpoch(hitEpoch), .nonceValid(nv0),
        .nonceReady(nonceReady), .nonce(nn0), .overflow(ov0), .searchDone(sd0));

    nonce_sequencer #(.NONCE_START(32'hFFFF_FFFE), .NONCE_STEP(32'd1), .HIT_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .stateValid(stateValid), .newBlock(newBlock),
        .initialState(initialState), .coreValid(cv1), .coreReady(coreReady),
        .coreState(cs1), .coreNonce(cn1), .coreEpoch(ce1), .hitValid(hitValid),
        .hitNonce(hitNonce), .hitEpoch(hitEpoch), .nonceValid(nv1),
        .nonceReady(nonceReady), .nonce(nn1), .overflow(ov1), .searchDone(sd1));

    task automatic chk(input string tag, input logic [351:0] obs, input logic [351:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_nonce[d] = 0;
            m_run[d]   = 0;
            m_exh[d]   = 0;
        end
        m_state = '0;
        m_epoch = 0;
        m_ovf   = 0;
        hq.delete();
    endtask

    // Apply one clock edge's worth of the rules to the model, using the inputs as sampled.
    task automatic model_step();
        bit start;
        bit pop;
        bit push;
        start = stateValid && newBlock;
        pop   = (hq.size() > 0) && nonceReady;
        push  = hitValid && (hitEpoch == m_epoch) && !start;
        if (start) begin
            m_state = initialState;
            m_epoch = !m_epoch;
            m_ovf   = 0;
            hq.delete();
            for (int d = 0; d < 2; d++) begin
                m_nonce[d] = m_start[d];
                m_run[d]   = 1;
                m_exh[d]   = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_run[d] && coreReady) begin
                    if (m_nonce[d] + 1 > TOP) begin
                        m_run[d] = 0;
                        m_exh[d] = 1;
                    end else begin
                        m_nonce[d] = m_nonce[d] + 1;
                    end
                end
            end
            if (pop) begin
                $display("[TB] nonce buffer takes %08h", hq[0]);
                void'(hq.pop_front());
            end
            if (push) begin
                if (hq.size() < DEPTH) hq.push_back(hitNonce);
                else m_ovf = 1;
            end
        end
    endtask

    task automatic check_dut(input int d, input logic cv, input logic [31:0] cn,
                             input logic [351:0] cs, input logic ce, input logic nv,
                             input logic [31:0] nn, input logic ov, input logic sd);
        logic [31:0] exp_head;
        exp_head = (hq.size() > 0) ? hq[0] : 32'h0;
        chk($sformatf("d%0d coreValid", d), 352'(cv), 352'(m_run[d]));
        if (m_run[d]) chk($sformatf("d%0d coreNonce", d), 352'(cn), 352'(m_nonce[d][31:0]));
        chk($sformatf("d%0d coreState", d), cs, m_state);
        chk($sformatf("d%0d coreEpoch", d), 352'(ce), 352'(m_epoch));
        chk($sformatf("d%0d nonceValid", d), 352'(nv), 352'(hq.size() > 0));
        chk($sformatf("d%0d nonce", d), 352'(nn), 352'(exp_head));
        chk($sformatf("d%0d overflow", d), 352'(ov), 352'(m_ovf));
        chk($sformatf("d%0d searchDone", d), 352'(sd), 352'(m_exh[d] && hq.size() == 0));
    endtask

    task automatic check_all();
        check_dut(0, cv0, cn0, cs0, ce0, nv0, nn0, ov0, sd0);
        check_dut(1, cv1, cn1, cs1, ce1, nv1, nn1, ov1, sd1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        stateValid = 0; newBlock = 0; hitValid = 0; hitEpoch = 0;
        hitNonce = '0; nonceReady = 0; coreReady = 0;
    endtask

    task automatic rand_state(output logic [351:0] s);
        for (int i = 0; i < 11; i++) s[i*32 +: 32] = $urandom();
    endtask

    task automatic check_reset_values();
        chk("rst coreNonce0", 352'(cn0), 352'(0));
        chk("rst coreNonce1", 352'(cn1), 352'(0));
        check_all();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        initialState = '0;
        model_reset();
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b1;

        // first block, core always ready: 0,1,2,3,4 on dut0; dut1 wraps and exhausts
        rand_state(initialState);
        stateValid = 1; newBlock = 1; coreReady = 1;
        cycle();
        stateValid = 0; newBlock = 0;
        rand_state(initialState);
        for (int i = 0; i < 5; i++) cycle();
        chk("wrap searchDone", 352'(sd1), 352'(1));
        chk("first epoch", 352'(ce0), 352'(1));

        // stateValid without newBlock is ignored
        stateValid = 1;
        cycle();
        stateValid = 0;

        // run to nonce 7, then stall the core for 3 cycles
        while (m_nonce[0] < 7) cycle();
        coreReady = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall nonce", 352'(cn0), 352'(7));
        end
        coreReady = 1;
        cycle();
        chk("after stall", 352'(cn0), 352'(8));

        // five matching hits into a depth-4 FIFO with the buffer stalled
        for (int i = 0; i < 5; i++) begin
            hitValid = 1; hitEpoch = m_epoch; hitNonce = 32'h10 + 32'(i);
            cycle();
        end
        hitValid = 0;
        chk("hit overflow", 352'(ov0), 352'(1));
        nonceReady = 1;
        for (int i = 0; i < 5; i++) cycle();
        nonceReady = 0;

        // new block coinciding with a hit, then a stale-epoch hit
        stateValid = 1; newBlock = 1; hitValid = 1; hitEpoch = m_epoch; hitNonce = 32'h55;
        rand_state(initialState);
        cycle();
        stateValid = 0; newBlock = 0;
        hitEpoch = !m_epoch; hitNonce = 32'h66;
        cycle();
        hitValid = 0;
        cycle();
        chk("stale nv", 352'(nv0), 352'(0));
        chk("stale ovf", 352'(ov0), 352'(0));

        // fill the FIFO, then push 0x20 with a simultaneous pop
        for (int i = 0; i < 4; i++) begin
            hitValid = 1; hitEpoch = m_epoch; hitNonce = 32'h30 + 32'(i);
            cycle();
        end
        nonceReady = 1; hitNonce = 32'h20;
        cycle();
        hitValid = 0; nonceReady = 0;
        chk("full pushpop ovf", 352'(ov0), 352'(0));
        nonceReady = 1;
        for (int i = 0; i < 4; i++) cycle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            newBlock   = $urandom_range(0, 1);
            stateValid = ($urandom_range(0, 29) == 0);
            if (stateValid) rand_state(initialState);
            coreReady  = $urandom_range(0, 1);
            nonceReady = ($urandom_range(0, 3) == 0);
            hitValid   = $urandom_range(0, 1);
            hitEpoch   = ($urandom_range(0, 9) < 8) ? m_epoch : !m_epoch;
            hitNonce   = $urandom();
            cycle();
        end

        // asynchronous reset in the middle of activity
        idle_inputs();
        hitValid = 1; hitEpoch = m_epoch; hitNonce = 32'hABCD;
        coreReady = 1;
        cycle();
        rst = 1'b0;
        #1;
        model_reset();
        check_reset_values();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
